fft_butterfly_sequencer: RTL
============================

Name: fft_butterfly_sequencer

Overview:
- Control-side counterpart of the radix-2 butterfly MAC in the 32-point FFT datapath.
- Walks all 5 DIT stages × 16 butterflies, driving:
  - operand-memory read addresses,
  - the twiddle ROM index,
  - the MAC `sel` phase sequence 0..4,
  - delayed write-back addresses for the MAC results.
- Sits between the top-level FFT controller (start/done) and the operand RAM / twiddle ROM / MAC.

Parameters:
- LOG2N, 5, log2 of FFT length. N = 2^LOG2N = 32.
- SEL_STEPS, 5, MAC phase cycles per butterfly. `sel` counts 0..SEL_STEPS-1.
- WB_DELAY, 1, cycles from the `sel` = SEL_STEPS-1 cycle to the write-back strobe (MAC output latency). Must be ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request a full FFT pass; sampled only in IDLE.
- busy  output  1  high from the first RUN cycle through the last DRAIN cycle.
- done  output  1  one-cycle pulse when the pass completes.
- rd_en  output  1  operand read strobe; pulses in the `sel` = 0 cycle of each butterfly.
- rd_addr_a  output  LOG2N  upper butterfly operand address (MAC in1).
- rd_addr_b  output  LOG2N  lower butterfly operand address (MAC in2).
- tw_addr  output  LOG2N-1  twiddle ROM index (MAC constant).
- sel  output  3  MAC phase select.
- mac_valid  output  1  high while `sel` is meaningful (RUN state).
- wr_en  output  1  result write strobe (MAC out1/out2).
- wr_addr_a  output  LOG2N  destination for out1.
- wr_addr_b  output  LOG2N  destination for out2.
- stage  output  3  current stage 0..LOG2N-1.
- bfly  output  LOG2N-1  current butterfly index 0..N/2-1.

Behaviour:
- Reset:
  - All outputs 0.
  - State IDLE; counters and write-back pipeline cleared.
  - Takes effect immediately, including mid-pass; no partial resume.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start = 1 at a clock edge → RUN.
  - The next cycle is cycle 0 with stage = 0, bfly = 0, sel = 0.
- RUN:
  - `sel` increments every cycle 0..SEL_STEPS-1.
  - On wrap, `bfly` increments.
  - After bfly = N/2-1 with sel = SEL_STEPS-1 → DRAIN.
- Addresses (combinational from registered stage s and bfly k, held constant for all SEL_STEPS cycles of a butterfly):
  - span = 2^s, pos = k mod span, grp = k >> s.
  - rd_addr_a = grp·2·span + pos.
  - rd_addr_b = rd_addr_a + span.
  - tw_addr = pos << (LOG2N-1-s).
- Operand memory is assumed loaded in bit-reversed order; in-place results.
- Write-back:
  - wr_en pulses exactly WB_DELAY cycles after each `sel` = SEL_STEPS-1 cycle.
  - wr_addr_a/b carry that butterfly's read addresses, via a WB_DELAY-deep register pipeline.
  - Butterflies within a stage touch disjoint addresses, so in-stage overlap is legal.
- DRAIN:
  - Lasts WB_DELAY cycles; mac_valid = 0, sel = 0, rd_en = 0.
  - Guarantees the stage's last write lands before the next stage's first read.
  - Then: if s < LOG2N-1, stage increments, bfly = 0, → RUN; else → DONE.
- DONE:
  - done = 1 and busy = 0 for one cycle, then → IDLE.
- Timing with defaults: stage s occupies RUN cycles s·81 .. s·81+79, DRAIN at s·81+80; done at cycle 405.
- start while RUN/DRAIN/DONE: ignored, not queued.
- start held high continuously: a new pass is accepted in the IDLE cycle after DONE.
- Outputs other than addresses are registered; wr_en never coincides with a stage-boundary read.

Test Plan:
- Hold reset = 0, toggle clk, drive start = 1 → all outputs stay 0, no RUN entry. Release reset with start = 0 → remains IDLE.
- start pulse; check cycle 0 → rd_en = 1, rd_addr_a = 0, rd_addr_b = 1, tw_addr = 0, sel = 0, busy = 1.
  - Cycles 1..4 → sel = 1..4, rd_en = 0.
  - Cycle 5 → a = 2, b = 3, rd_en = 1.
  - Cycle 5 also → wr_en = 1, wr_addr 0/1.
- Cycle 80 → DRAIN, mac_valid = 0. Cycle 81 → stage = 1, a = 0, b = 2, tw = 0. Cycle 86 → a = 1, b = 3, tw = 8.
- Stage 2, bfly 5 (cycle 162+25 = 187) → a = 9, b = 13, tw = 4. Stage 4, bfly 15 (cycle 399) → a = 15, b = 31, tw = 15.
- End of pass: cycle 404 → wr_en with wr_addr 15/31. Cycle 405 → done = 1, busy = 0. Cycle 406 → IDLE. Extra start pulses during RUN → no effect on the cycle count.
- Drive reset = 0 asynchronously mid-cycle during stage 2 → outputs 0 within the same cycle, no wr_en. After release + start → the pass restarts at stage 0, bfly 0.

Source files
------------

// File: rtl/fft_butterfly_sequencer_if.sv
// Bus between the FFT butterfly sequencer and the controller, operand RAM, twiddle ROM and MAC.
// The master side is the sequencer; the slave side is whatever consumes its strobes and addresses.
interface fft_butterfly_sequencer_if #(
    parameter int LOG2N = 5
);
    logic             start;
    logic             busy;
    logic             done;
    logic             rd_en;
    logic [LOG2N-1:0] rd_addr_a;
    logic [LOG2N-1:0] rd_addr_b;
    logic [LOG2N-2:0] tw_addr;
    logic [2:0]       sel;
    logic             mac_valid;
    logic             wr_en;
    logic [LOG2N-1:0] wr_addr_a;
    logic [LOG2N-1:0] wr_addr_b;
    logic [2:0]       stage;
    logic [LOG2N-2:0] bfly;

    modport master (
        input  start,
        output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr, sel, mac_valid,
        output wr_en, wr_addr_a, wr_addr_b, stage, bfly
    );

    modport slave (
        output start,
        input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr, sel, mac_valid,
        input  wr_en, wr_addr_a, wr_addr_b, stage, bfly
    );
endinterface

// File: rtl/fft_butterfly_sequencer.sv
// Control sequencer for an in-place radix-2 DIT FFT: walks every stage and butterfly, steps the MAC
// phase select, and replays each butterfly's addresses as a delayed write-back after the MAC latency.
module fft_butterfly_sequencer #(
    parameter int LOG2N     = 5,
    parameter int SEL_STEPS = 5,
    parameter int WB_DELAY  = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    fft_butterfly_sequencer_if.master      bus
);
    localparam int DCW = (WB_DELAY > 1) ? $clog2(WB_DELAY) : 1;
    localparam logic [2:0]       SEL_LAST   = 3'(SEL_STEPS - 1);
    localparam logic [2:0]       STAGE_LAST = 3'(LOG2N - 1);
    localparam logic [LOG2N-2:0] BFLY_LAST  = {(LOG2N-1){1'b1}};
    localparam logic [DCW-1:0]   DRAIN_LAST = DCW'(WB_DELAY - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state_q;
    logic [2:0]       stage_q;
    logic [LOG2N-2:0] bfly_q;
    logic [2:0]       sel_q;
    logic [DCW-1:0]   drain_cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             rd_en_q;
    logic             mac_valid_q;

    logic             wb_en_q   [WB_DELAY];
    logic [LOG2N-1:0] wb_addr_a_q [WB_DELAY];
    logic [LOG2N-1:0] wb_addr_b_q [WB_DELAY];

    logic [LOG2N-2:0] pos_mask;
    logic [LOG2N-2:0] pos;
    logic [LOG2N-2:0] grp_hi;
    logic [LOG2N-1:0] addr_a;
    logic [LOG2N-1:0] addr_b;
    logic [LOG2N-2:0] tw;

    // grp_hi is (k >> s) << s, so doubling it gives grp*2*span without a multiplier.
    always_comb begin
        pos_mask = ~({(LOG2N-1){1'b1}} << stage_q);
        pos      = bfly_q & pos_mask;
        grp_hi   = bfly_q & ~pos_mask;
        addr_a   = {grp_hi, 1'b0} + {1'b0, pos};
        addr_b   = addr_a + (LOG2N'(1) << stage_q);
        tw       = pos << (STAGE_LAST - stage_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            stage_q     <= '0;
            bfly_q      <= '0;
            sel_q       <= '0;
            drain_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            mac_valid_q <= 1'b0;
            for (int i = 0; i < WB_DELAY; i++) begin
                wb_en_q[i]     <= 1'b0;
                wb_addr_a_q[i] <= '0;
                wb_addr_b_q[i] <= '0;
            end
        end else begin
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;

            // Write-back pipe is loaded on the last MAC phase and just shifts afterwards.
            wb_en_q[0]     <= mac_valid_q && (sel_q == SEL_LAST);
            wb_addr_a_q[0] <= (mac_valid_q && (sel_q == SEL_LAST)) ? addr_a : '0;
            wb_addr_b_q[0] <= (mac_valid_q && (sel_q == SEL_LAST)) ? addr_b : '0;
            for (int i = 1; i < WB_DELAY; i++) begin
                wb_en_q[i]     <= wb_en_q[i-1];
                wb_addr_a_q[i] <= wb_addr_a_q[i-1];
                wb_addr_b_q[i] <= wb_addr_b_q[i-1];
            end

            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q     <= RUN;
                        stage_q     <= '0;
                        bfly_q      <= '0;
                        sel_q       <= '0;
                        busy_q      <= 1'b1;
                        mac_valid_q <= 1'b1;
                        rd_en_q     <= 1'b1;
                    end
                end
                RUN: begin
                    if (sel_q == SEL_LAST) begin
                        sel_q <= '0;
                        if (bfly_q == BFLY_LAST) begin
                            state_q     <= DRAIN;
                            mac_valid_q <= 1'b0;
                            drain_cnt_q <= '0;
                        end else begin
                            bfly_q  <= bfly_q + 1'b1;
                            rd_en_q <= 1'b1;
                        end
                    end else begin
                        sel_q <= sel_q + 1'b1;
                    end
                end
                DRAIN: begin
                    // Hold off the next stage's first read until the last write has landed.
                    if (drain_cnt_q == DRAIN_LAST) begin
                        bfly_q <= '0;
                        if (stage_q == STAGE_LAST) begin
                            state_q <= DONE;
                            stage_q <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= RUN;
                            stage_q     <= stage_q + 1'b1;
                            mac_valid_q <= 1'b1;
                            rd_en_q     <= 1'b1;
                        end
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.sel       = sel_q;
    assign bus.mac_valid = mac_valid_q;
    assign bus.stage     = stage_q;
    assign bus.bfly      = bfly_q;
    assign bus.rd_addr_a = mac_valid_q ? addr_a : '0;
    assign bus.rd_addr_b = mac_valid_q ? addr_b : '0;
    assign bus.tw_addr   = mac_valid_q ? tw : '0;
    assign bus.wr_en     = wb_en_q[WB_DELAY-1];
    assign bus.wr_addr_a = wb_addr_a_q[WB_DELAY-1];
    assign bus.wr_addr_b = wb_addr_b_q[WB_DELAY-1];
endmodule
